// File: rtl/instruction_fetch.sv
// Fetch stage: sequential PC generation, credit-limited in-order word reads, PC/word pairing.
// Define MIST32_FETCH_BTB_EN to enable the 16-entry direct-mapped branch target buffer.
module instruction_fetch #(
   parameter logic [31:0] P_RESET_VECTOR    = 32'h0000_0000,
   parameter int unsigned P_MAX_OUTSTANDING = 4
) (
   input  logic        iCLOCK,
   input  logic        inRESET,
   input  logic        iRESET_SYNC,
   input  logic        iEVENT_START,
   input  logic [31:0] iEVENT_START_ADDR,
   output logic        oMEM_REQ,
   output logic [31:0] oMEM_ADDR,
   input  logic        iMEM_LOCK,
   input  logic        iMEM_VALID,
   input  logic [31:0] iMEM_DATA,
   output logic        oNEXT_INST_VALID,
   output logic        oNEXT_BRANCH_PREDICT,
   output logic [31:0] oNEXT_BRANCH_PREDICT_ADDR,
   output logic [31:0] oNEXT_INST,
   output logic [31:0] oNEXT_PC,
   input  logic        iNEXT_FETCH_STOP,
   input  logic        iNEXT_LOCK,
   input  logic        iBTB_UPD_VALID,
   input  logic [31:0] iBTB_UPD_PC,
   input  logic [31:0] iBTB_UPD_TARGET
);
   localparam int unsigned PW = $clog2(P_MAX_OUTSTANDING);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {IDLE, FETCH, FLUSH} stateT;
   stateT state, stateNext;

   logic [31:0]   pc, nextPc, flushTarget;
   logic          predTaken;
   logic [31:0]   predAddr;
   logic [CW-1:0] credits, inflight, inflightNext, discardCnt, rqCount;
   logic [PW-1:0] pcqWr, pcqRd, rqWr, rqRd;

   logic [31:0] pcqPc   [P_MAX_OUTSTANDING];
   logic        pcqPred [P_MAX_OUTSTANDING];
   logic [31:0] pcqTgt  [P_MAX_OUTSTANDING];
   logic [31:0] rqPc    [P_MAX_OUTSTANDING];
   logic [31:0] rqInst  [P_MAX_OUTSTANDING];
   logic        rqPred  [P_MAX_OUTSTANDING];
   logic [31:0] rqTgt   [P_MAX_OUTSTANDING];

   logic        outValid, outPred;
   logic [31:0] outPc, outInst, outPredAddr;

   logic flush, memReq, accept, discardResp, keepResp;
   logic outLoad, fromQueue, fromBypass, rqPush, rqPop, relCredit;

   assign flush       = iRESET_SYNC | iEVENT_START;
   assign flushTarget = iRESET_SYNC ? P_RESET_VECTOR : iEVENT_START_ADDR;
   assign memReq      = (state != IDLE) && !iNEXT_FETCH_STOP && !iNEXT_LOCK &&
                        (credits < CW'(P_MAX_OUTSTANDING)) && !flush;
   assign accept      = memReq && !iMEM_LOCK;

   // A response landing in the flush cycle is dropped outright and never enters the discard count.
   assign discardResp = iMEM_VALID && ((discardCnt != '0) || flush);
   assign keepResp    = iMEM_VALID && !discardResp;

   // Output register takes the queue head first; with an empty queue the live response bypasses it.
   assign outLoad    = !outValid || !iNEXT_LOCK;
   assign fromQueue  = outLoad && (rqCount != '0);
   assign fromBypass = outLoad && (rqCount == '0) && keepResp;
   assign rqPush     = keepResp && !fromBypass;
   assign rqPop      = fromQueue;
   assign relCredit  = fromQueue || fromBypass || discardResp;

   assign inflightNext = inflight + CW'(accept) - CW'(iMEM_VALID);

`ifdef MIST32_FETCH_BTB_EN
   logic [15:0] btbValid;
   logic [25:0] btbTag    [16];
   logic [31:0] btbTarget [16];
   logic [3:0]  btbIdx;
   logic        btbHit;
   logic [1:0]  unusedUpdLsb;

   assign btbIdx       = pc[5:2];
   assign btbHit       = btbValid[btbIdx] && (btbTag[btbIdx] == pc[31:6]);
   assign predTaken    = btbHit;
   assign predAddr     = btbHit ? btbTarget[btbIdx] : '0;
   assign nextPc       = btbHit ? btbTarget[btbIdx] : pc + 32'd4;
   assign unusedUpdLsb = iBTB_UPD_PC[1:0];

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         btbValid <= '0;
      end else if (iBTB_UPD_VALID) begin
         btbValid[iBTB_UPD_PC[5:2]] <= 1'b1;
      end
   end

   always_ff @(posedge iCLOCK) begin
      if (iBTB_UPD_VALID) begin
         btbTag[iBTB_UPD_PC[5:2]]    <= iBTB_UPD_PC[31:6];
         btbTarget[iBTB_UPD_PC[5:2]] <= iBTB_UPD_TARGET;
      end
   end
`else
   logic unusedBtb;

   assign predTaken = 1'b0;
   assign predAddr  = '0;
   assign nextPc    = pc + 32'd4;
   assign unusedBtb = ^{iBTB_UPD_VALID, iBTB_UPD_PC, iBTB_UPD_TARGET};
`endif

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:    stateNext = FETCH;
         FETCH:   if (flush && (inflight != '0)) stateNext = FLUSH;
         FLUSH:   if (!flush && (discardCnt == '0)) stateNext = FETCH;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         state       <= IDLE;
         pc          <= P_RESET_VECTOR;
         credits     <= '0;
         inflight    <= '0;
         discardCnt  <= '0;
         pcqWr       <= '0;
         pcqRd       <= '0;
         rqWr        <= '0;
         rqRd        <= '0;
         rqCount     <= '0;
         outValid    <= 1'b0;
         outPc       <= '0;
         outInst     <= '0;
         outPred     <= 1'b0;
         outPredAddr <= '0;
      end else begin
         state    <= stateNext;
         inflight <= inflightNext;
         // The PC queue tracks reads in flight, so it survives a flush and pops stale entries too.
         if (accept)     pcqWr <= pcqWr + 1'b1;
         if (iMEM_VALID) pcqRd <= pcqRd + 1'b1;
         if (flush) begin
            pc         <= flushTarget;
            credits    <= inflightNext;
            discardCnt <= inflightNext;
            rqWr       <= '0;
            rqRd       <= '0;
            rqCount    <= '0;
            outValid   <= 1'b0;
         end else begin
            if (accept)      pc <= nextPc;
            credits <= credits + CW'(accept) - CW'(relCredit);
            if (discardResp) discardCnt <= discardCnt - 1'b1;
            if (rqPush)      rqWr <= rqWr + 1'b1;
            if (rqPop)       rqRd <= rqRd + 1'b1;
            rqCount <= rqCount + CW'(rqPush) - CW'(rqPop);
            if (fromQueue) begin
               outValid    <= 1'b1;
               outPc       <= rqPc[rqRd];
               outInst     <= rqInst[rqRd];
               outPred     <= rqPred[rqRd];
               outPredAddr <= rqTgt[rqRd];
            end else if (fromBypass) begin
               outValid    <= 1'b1;
               outPc       <= pcqPc[pcqRd];
               outInst     <= iMEM_DATA;
               outPred     <= pcqPred[pcqRd];
               outPredAddr <= pcqTgt[pcqRd];
            end else if (outLoad) begin
               outValid    <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge iCLOCK) begin
      if (accept) begin
         pcqPc[pcqWr]   <= pc;
         pcqPred[pcqWr] <= predTaken;
         pcqTgt[pcqWr]  <= predAddr;
      end
      if (rqPush) begin
         rqPc[rqWr]   <= pcqPc[pcqRd];
         rqInst[rqWr] <= iMEM_DATA;
         rqPred[rqWr] <= pcqPred[pcqRd];
         rqTgt[rqWr]  <= pcqTgt[pcqRd];
      end
   end

   assign oMEM_REQ                  = memReq;
   assign oMEM_ADDR                 = pc;
   assign oNEXT_INST_VALID          = outValid;
   assign oNEXT_BRANCH_PREDICT      = outPred;
   assign oNEXT_BRANCH_PREDICT_ADDR = outPredAddr;
   assign oNEXT_INST                = outInst;
   assign oNEXT_PC                  = outPc;
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Front-end fetch stage that generates sequential PCs, issues word reads to the instruction memory port, and pairs each returned word with its PC.
- Results go to the instruction buffer stage downstream; that stage's fetch-stop and lock outputs throttle this block.
- Memory is in-order with a variable-latency response. Outstanding reads are credit-limited so no response is ever dropped.

Parameters:
P_RESET_VECTOR, 32'h0000_0000, PC loaded at reset and on iRESET_SYNC.
P_MAX_OUTSTANDING, 4, maximum of (reads in flight + entries in response queue); power of two, 2..8.

Ports:
iCLOCK  in  1  clock.
inRESET  in  1  asynchronous active-low reset.
iRESET_SYNC  in  1  synchronous reset: flush and PC <= P_RESET_VECTOR.
iEVENT_START  in  1  redirect pulse: flush and PC <= iEVENT_START_ADDR.
iEVENT_START_ADDR  in  32  redirect target, word aligned.
oMEM_REQ  out  1  read request.
oMEM_ADDR  out  32  read address (= PC).
iMEM_LOCK  in  1  memory busy; request not accepted this cycle.
iMEM_VALID  in  1  read data valid (in order).
iMEM_DATA  in  32  instruction word.
oNEXT_INST_VALID  out  1  output word valid.
oNEXT_BRANCH_PREDICT  out  1  predicted-taken flag.
oNEXT_BRANCH_PREDICT_ADDR  out  32  predicted target.
oNEXT_INST  out  32  instruction.
oNEXT_PC  out  32  PC of instruction.
iNEXT_FETCH_STOP  in  1  downstream nearly full: issue no new requests.
iNEXT_LOCK  in  1  downstream full: hold output register.
iBTB_UPD_VALID  in  1  BTB write strobe (optional feature).
iBTB_UPD_PC  in  32  branch PC for BTB write.
iBTB_UPD_TARGET  in  32  branch target for BTB write.

Behaviour:
Reset (inRESET=0):
- All outputs 0.
- PC = P_RESET_VECTOR; state IDLE; all counters and queues empty.

State machine:
- IDLE -> FETCH after one cycle.
- FETCH -> FLUSH on iEVENT_START or iRESET_SYNC while any read is in flight.
- FLUSH -> FETCH when the discard counter reaches 0.

Request issue:
- oMEM_REQ = (state != IDLE) && !iNEXT_FETCH_STOP && !iNEXT_LOCK && credits < P_MAX_OUTSTANDING && !iEVENT_START && !iRESET_SYNC.
- A request is accepted when oMEM_REQ && !iMEM_LOCK. On accept: PC += 4 (wraps at 2^32), the PC is pushed to a PC queue, and credits increment.
- Requests remain legal in FLUSH.

Credits:
- Credits = reads in flight + response-queue entries.
- A response entering the queue does not change credits.
- Credits decrement when the output register loads from the queue, or when a stale response is discarded.
- Accept and release in the same cycle net to zero.

Responses:
- An iMEM_VALID word is paired with the head of the PC queue.
- If the discard counter > 0, the word is dropped and the discard counter decrements; otherwise the word is pushed to the response queue.

Output register:
- Loads the response-queue head when !oNEXT_INST_VALID || !iNEXT_LOCK.
- Valid clears when the queue is empty and iNEXT_LOCK=0.
- While iNEXT_LOCK=1, valid and all data hold stable.
- Latency from iMEM_VALID to oNEXT_INST_VALID is 1 cycle when the queue is empty and the output is unlocked.

Flush (iEVENT_START or iRESET_SYNC):
- Next cycle: output valid = 0 and response queue emptied.
- Discard counter = reads in flight, including a request accepted that same cycle. A response arriving that same cycle is itself dropped and is not counted.
- PC loaded from the new target.
- iRESET_SYNC has priority over iEVENT_START.
- A flush during FLUSH reloads the PC; the discard counter is recomputed from reads in flight.

Optional Feature:
Macro: MIST32_FETCH_BTB_EN.
- Defined:
  - 16-entry direct-mapped BTB: index PC[5:2], tag PC[31:6], valid bit per entry.
  - On a hit at request accept, next PC = stored target; predict=1 and target travel with the PC queue to the output.
  - iBTB_UPD_VALID writes the entry and sets its valid bit.
  - Reset clears all valid bits; flush does not.
- Undefined:
  - No BTB storage; next PC always PC+4.
  - oNEXT_BRANCH_PREDICT=0, oNEXT_BRANCH_PREDICT_ADDR=0.
  - iBTB_UPD_* ignored.

Test Plan:
- Reset release, memory latency 1, no stalls: requests at 0x0,0x4,0x8,... -> oNEXT_PC 0x0,0x4,0x8 on consecutive cycles, oNEXT_INST matching iMEM_DATA.
- Memory latency 10, P_MAX_OUTSTANDING=4: at most 4 requests before the first response; credits never exceed 4; no word lost.
- iNEXT_LOCK held 6 cycles with 3 reads in flight: output holds the same PC/INST; queue absorbs 3 words; after release, PCs appear in order with no gaps or duplicates.
- iEVENT_START to 0x1000 with 3 reads in flight: the 3 stale words are discarded; first output after the event is PC 0x1000; iRESET_SYNC in the same cycle wins with P_RESET_VECTOR.
- iNEXT_FETCH_STOP=1 for 5 cycles: no oMEM_REQ during those cycles; in-flight responses still delivered; fetch resumes at the correct PC.
- With MIST32_FETCH_BTB_EN: update PC 0x20 -> target 0x400; refetch 0x20 -> next request 0x400, output PC 0x20 with predict=1 and addr 0x400.
